// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving ps2_clk/ps2_data open-drain via oe pins.
// Define PS2_HOST_TX_RETRY_EN to retry a failed frame once before reporting tx_err.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_ACK       = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    // The start bit goes out one cycle before the clock is released, so INHIBIT_CYCLES must be >= 2.
    localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_START = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    function automatic logic odd_parity(input logic [7:0] b);
        odd_parity = ~^b;
    endfunction

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [3:0]        idx_r, idx_s;
    logic [9:0]        shift_r, shift_s;
    logic [7:0]        byte_r, byte_s;
    logic              clk_oe_r, clk_oe_s;
    logic              data_oe_r, data_oe_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic [2:0]        clk_sync_r;
    logic [1:0]        data_sync_r;
    logic              fall_s;
    logic              line_idle_s;
    logic              timeout_s;
    logic              fail_s;
    logic              retry_take_s;
`ifdef PS2_HOST_TX_RETRY_EN
    logic              retry_r, retry_s;
`endif

    // Line synchronisers; the third clock flop provides the previous level for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_r  <= 3'b111;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[1:0], ps2_clk_in};
            data_sync_r <= {data_sync_r[0], ps2_data_in};
        end
    end

    // Frame events: device clock fall, bus idle, timeout and the combined failure condition.
    always_comb begin
        fall_s      = clk_sync_r[2] & ~clk_sync_r[1];
        line_idle_s = clk_sync_r[1] & data_sync_r[1];
        timeout_s   = (cnt_r == TO_LAST);
        fail_s      = 1'b0;
        case (state_r)
            ST_SHIFT:     fail_s = ~fall_s & timeout_s;
            ST_ACK:       fail_s = fall_s ? data_sync_r[1] : timeout_s;
            ST_WAIT_IDLE: fail_s = ~line_idle_s & timeout_s;
            default:      fail_s = 1'b0;
        endcase
`ifdef PS2_HOST_TX_RETRY_EN
        retry_take_s = fail_s & ~retry_r;
`else
        retry_take_s = 1'b0;
`endif
    end

    // State register plus all registered outputs and datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            idx_r     <= 4'd0;
            shift_r   <= 10'd0;
            byte_r    <= 8'd0;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_r   <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            idx_r     <= idx_s;
            shift_r   <= shift_s;
            byte_r    <= byte_s;
            clk_oe_r  <= clk_oe_s;
            data_oe_r <= data_oe_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            err_r     <= err_s;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_r   <= retry_s;
`endif
        end
    end

    // Next-state logic; a failure either re-enters INHIBIT (retry) or returns to IDLE.
    always_comb begin
        state_s = state_r;
        if (fail_s) begin
            state_s = retry_take_s ? ST_INHIBIT : ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tx_start) state_s = ST_INHIBIT;
                    else          state_s = ST_IDLE;
                end
                ST_INHIBIT: begin
                    if (cnt_r == INH_LAST) state_s = ST_SHIFT;
                    else                   state_s = ST_INHIBIT;
                end
                ST_SHIFT: begin
                    if (fall_s && (idx_r == 4'd9)) state_s = ST_ACK;
                    else                           state_s = ST_SHIFT;
                end
                ST_ACK: begin
                    if (fall_s) state_s = ST_WAIT_IDLE;
                    else        state_s = ST_ACK;
                end
                ST_WAIT_IDLE: begin
                    if (line_idle_s) state_s = ST_IDLE;
                    else             state_s = ST_WAIT_IDLE;
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Output and datapath next values.
    always_comb begin
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        shift_s   = shift_r;
        byte_s    = byte_r;
        clk_oe_s  = clk_oe_r;
        data_oe_s = data_oe_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_s   = retry_r;
`endif
        case (state_r)
            ST_IDLE: begin
                clk_oe_s  = 1'b0;
                data_oe_s = 1'b0;
                busy_s    = 1'b0;
                if (tx_start) begin
                    byte_s   = tx_data;
                    busy_s   = 1'b1;
                    cnt_s    = CNT_ZERO;
                    clk_oe_s = 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
                    retry_s  = 1'b0;
`endif
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            ST_INHIBIT: begin
                if (cnt_r == INH_LAST) begin
                    clk_oe_s = 1'b0;
                    cnt_s    = CNT_ZERO;
                    idx_s    = 4'd0;
                    shift_s  = {1'b1, odd_parity(byte_r), byte_r};
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                    if (cnt_r == INH_START) data_oe_s = 1'b1;
                    else                    data_oe_s = data_oe_r;
                end
            end
            ST_SHIFT: begin
                // Host changes data on the device's falling edge; device samples on the rising edge.
                if (fall_s) begin
                    data_oe_s = ~shift_r[0];
                    shift_s   = {1'b1, shift_r[9:1]};
                    idx_s     = idx_r + 4'd1;
                    cnt_s     = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_ACK: begin
                if (fall_s) cnt_s = CNT_ZERO;
                else        cnt_s = cnt_r + CNT_ONE;
            end
            ST_WAIT_IDLE: begin
                if (line_idle_s) begin
                    done_s    = 1'b1;
                    busy_s    = 1'b0;
                    clk_oe_s  = 1'b0;
                    data_oe_s = 1'b0;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                clk_oe_s  = 1'b0;
                data_oe_s = 1'b0;
                busy_s    = 1'b0;
            end
        endcase

        if (fail_s) begin
            data_oe_s = 1'b0;
            cnt_s     = CNT_ZERO;
            done_s    = 1'b0;
            if (retry_take_s) begin
                clk_oe_s = 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
                retry_s  = 1'b1;
`endif
            end else begin
                clk_oe_s = 1'b0;
                busy_s   = 1'b0;
                err_s    = 1'b1;
            end
        end else begin
            err_s = 1'b0;
        end
    end

    assign ps2_clk_oe  = clk_oe_r;
    assign ps2_data_oe = data_oe_r;
    assign tx_busy     = busy_r;
    assign tx_done     = done_r;
    assign tx_err      = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: device model on the wired-AND lines plus a per-cycle output model.
module tb_ps2_host_tx;
    localparam int N   = 20;
    localparam int T   = 400;
    localparam int H   = 15;
    localparam int BIG = 1 << 30;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    // Model: busy window [m_start, m_end), inhibit phase begins at m_inh, end pulse kind 0 none / 1 done / 2 err.
    int m_start = BIG;
    int m_inh   = BIG;
    int m_end   = BIG;
    int m_kind  = 0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(N), .TIMEOUT_CYCLES(T), .CNT_W(20)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [10:0] exp_bits(input logic [7:0] b);
        logic [10:0] r;
        r[0] = 1'b0;
        for (int i = 0; i < 8; i++) r[i+1] = b[i];
        r[9]  = ~^b;
        r[10] = 1'b1;
        return r;
    endfunction

    // Per-cycle comparison of every output against the model windows.
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_clk_oe", ps2_clk_oe, 0);
            check("rst_data_oe", ps2_data_oe, 0);
            check("rst_busy", tx_busy, 0);
            check("rst_done", tx_done, 0);
            check("rst_err", tx_err, 0);
        end else if (cyc < m_start || cyc > m_end) begin
            check("idle_clk_oe", ps2_clk_oe, 0);
            check("idle_data_oe", ps2_data_oe, 0);
            check("idle_busy", tx_busy, 0);
            check("idle_done", tx_done, 0);
            check("idle_err", tx_err, 0);
        end else if (cyc == m_end) begin
            check("end_done", tx_done, (m_kind == 1) ? 1 : 0);
            check("end_err", tx_err, (m_kind == 2) ? 1 : 0);
            check("end_busy", tx_busy, 0);
            check("end_clk_oe", ps2_clk_oe, 0);
            check("end_data_oe", ps2_data_oe, 0);
        end else begin
            check("busy", tx_busy, 1);
            check("no_done", tx_done, 0);
            check("no_err", tx_err, 0);
            if (cyc >= m_inh && cyc < m_inh + N) begin
                check("inh_clk_oe", ps2_clk_oe, 1);
                check("inh_data_oe", ps2_data_oe, (cyc == m_inh + N - 1) ? 1 : 0);
            end else if (cyc == m_inh + N) begin
                check("rel_clk_oe", ps2_clk_oe, 0);
                check("rel_start_bit", ps2_data_oe, 1);
            end else begin
                check("shift_clk_oe", ps2_clk_oe, 0);
            end
        end
    end

    task automatic pulse_start(input logic [7:0] b);
        tx_data  = b;
        tx_start = 1'b1;
        m_start  = cyc + 1;
        m_inh    = cyc + 1;
        m_end    = BIG;
        m_kind   = 0;
        tick();
        tx_start = 1'b0;
    endtask

    task automatic wait_release(output bit ok);
        int budget = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1 && tx_busy == 1'b1) && budget < 100) begin
            tick();
            budget++;
        end
        ok = (budget < 100);
        check("start_bit_seen", ok, 1);
    endtask

    // Device side of one frame: 11 clock pulses, bits sampled at rising edges, optional ack.
    task automatic dev_frame(input bit ack, input bit poke, output logic [10:0] bits);
        bit ok;
        bits = 11'bx;
        wait_release(ok);
        if (ok) begin
            bits[0] = ps2_data_in;
            wait_cycles(5);
            for (int k = 1; k <= 11; k++) begin
                dev_clk_low = 1'b1;
                if (k == 11 && !ack) begin
`ifdef PS2_HOST_TX_RETRY_EN
                    if (m_inh < m_start + 5) m_inh = cyc + 3;
                    else begin m_end = cyc + 3; m_kind = 2; end
`else
                    m_end  = cyc + 3;
                    m_kind = 2;
`endif
                end
                if (poke && k == 4) begin
                    tx_data  = 8'h00;
                    tx_start = 1'b1;
                    tick();
                    tx_start = 1'b0;
                    wait_cycles(H - 1);
                end else begin
                    wait_cycles(H);
                end
                dev_clk_low = 1'b0;
                if (k <= 10) bits[k] = ps2_data_in;
                if (k == 10 && ack) begin
                    wait_cycles(H / 2);
                    dev_data_low = 1'b1;
                    wait_cycles(H - H / 2);
                end else if (k < 11) begin
                    wait_cycles(H);
                end
            end
            if (ack) begin
                wait_cycles(2);
                dev_data_low = 1'b0;
                m_end  = cyc + 3;
                m_kind = 1;
                wait_cycles(6);
            end
        end
    endtask

    task automatic check_frame(input string nm, input logic [7:0] b, input logic [10:0] bits);
        logic [10:0] e;
        e = exp_bits(b);
        for (int i = 0; i < 11; i++) check($sformatf("%s_bit%0d", nm, i), bits[i], e[i]);
    endtask

    initial begin
        logic [10:0] bits;
        int a;
        bit ok;
        wait_cycles(3);
        check("reset_busy", tx_busy, 0);
        check("reset_clk_oe", ps2_clk_oe, 0);
        rst = 1'b1;
        wait_cycles(3);

        // 0xF4 acked
        pulse_start(8'hF4);
        dev_frame(1'b1, 1'b0, bits);
        check_frame("f4", 8'hF4, bits);
        check("f4_literal", bits, 11'b1_0_1111_0100_0);
        wait_cycles(5);

        // 0xED with an ignored tx_start during SHIFT, then 0xFF
        pulse_start(8'hED);
        dev_frame(1'b1, 1'b1, bits);
        check_frame("ed", 8'hED, bits);
        check("ed_parity", bits[9], 1);
        wait_cycles(5);
        pulse_start(8'hFF);
        dev_frame(1'b1, 1'b0, bits);
        check_frame("ff", 8'hFF, bits);
        check("ff_parity", bits[9], 1);
        wait_cycles(5);

        // Device never clocks: timeout
        a = cyc + 1;
        pulse_start(8'hF4);
`ifdef PS2_HOST_TX_RETRY_EN
        m_end  = a + 2 * (N + T);
        m_kind = 2;
        while (cyc < a + N + T - 1) tick();
        m_inh = a + N + T;
`else
        m_end  = a + N + T;
        m_kind = 2;
`endif
        while (cyc < m_end + 3) tick();

        // No ack on the 11th clock
        pulse_start(8'hA5);
        dev_frame(1'b0, 1'b0, bits);
        check_frame("noack", 8'hA5, bits);
`ifdef PS2_HOST_TX_RETRY_EN
        dev_frame(1'b1, 1'b0, bits);
        check_frame("retry", 8'hA5, bits);
`endif
        wait_cycles(20);

        // Reset mid-SHIFT while data is pulled low
        pulse_start(8'hF4);
        wait_release(ok);
        for (int k = 0; k < 2; k++) begin
            dev_clk_low = 1'b1;
            wait_cycles(H);
            dev_clk_low = 1'b0;
            wait_cycles(H);
        end
        check("pre_rst_data_oe", ps2_data_oe, 1);
        #2;
        rst   = 1'b0;
        m_end = cyc;
        m_kind = 0;
        #1;
        check("async_clk_oe", ps2_clk_oe, 0);
        check("async_data_oe", ps2_data_oe, 0);
        check("async_busy", tx_busy, 0);
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(3);
        pulse_start(8'hF4);
        dev_frame(1'b1, 1'b0, bits);
        check_frame("post_rst", 8'hF4, bits);
        wait_cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Sits beside the PS/2 scan-code receiver on the same ps2_clk/ps2_data pair.
- Drives both lines open-drain through output-enable pins; the top level builds the tristate buffers.
- tx_busy gates the receiver so it does not decode host-driven frames.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles the host holds ps2_clk low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, max clk cycles between device clock edges, and for the final idle wait (15 ms at 50 MHz).
- CNT_W, 20, width of the shared timing counter; must hold the larger of the two cycle parameters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tx_start  in  1  one-cycle request; accepted only when tx_busy=0.
- tx_data  in  8  command byte; latched on the accept cycle.
- ps2_clk_in  in  1  raw PS/2 clock line level.
- ps2_data_in  in  1  raw PS/2 data line level.
- ps2_clk_oe  out  1  1 = pull ps2_clk low, 0 = release.
- ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release.
- tx_busy  out  1  high from the accept cycle until return to IDLE.
- tx_done  out  1  one-cycle pulse: frame acknowledged by the device.
- tx_err  out  1  one-cycle pulse: no ack, or timeout.

Behaviour:
- Reset (rst=0, async): every output is 0, so both lines are released; state IDLE; counters cleared. Reset mid-frame releases both lines immediately and sends no pulse.
- Input sync: ps2_clk_in and ps2_data_in each pass through 2 flops. A third flop on the clock path gives fall = prev & ~cur, one cycle wide.
- Frame bits: shift register {stop=1, parity=~^tx_data (odd parity), tx_data}. Sent LSB first.
- State IDLE: tx_busy=0. On tx_start, latch the data, set tx_busy=1, clear the counter, go to INHIBIT. tx_start while busy is ignored.
- State INHIBIT: ps2_clk_oe=1. When the counter reaches INHIBIT_CYCLES-1, set ps2_data_oe=1 (start bit 0). Next cycle release ps2_clk_oe, clear the counter and bit index, go to SHIFT.
- State SHIFT: on each fall, ps2_data_oe <= ~bit[idx] and idx++.
  - idx 0-7 are the data bits; idx 8 is parity; idx 9 is stop (line released).
  - After the 10th fall go to ACK.
  - The counter clears on every fall.
- State ACK: on the next fall, sample synced ps2_data. 0 = acknowledged, go to WAIT_IDLE. 1 = error path.
- State WAIT_IDLE: wait until synced clock=1 and data=1. Then pulse tx_done for 1 cycle, drop tx_busy in the same cycle, go to IDLE.
- Timeout: in SHIFT, ACK and WAIT_IDLE, if the counter reaches TIMEOUT_CYCLES, take the error path.
- Error path: release both oe, pulse tx_err for 1 cycle, drop tx_busy, go to IDLE.
- tx_done and tx_err are never asserted in the same cycle.
- A fall while in INHIBIT is ignored; the host owns the clock then.
- Latency: accept to start bit = INHIBIT_CYCLES cycles. Start bit to idle is paced by the device (about 11 clock periods, 1.1 ms at 10 kHz).

Optional Feature:
- Macro PS2_HOST_TX_RETRY_EN.
- Defined: on the first no-ack or timeout, re-enter INHIBIT with the same latched byte; tx_busy stays high. Only a second failure pulses tx_err. A 1-bit retry flag clears on accept.
- Not defined: the first failure pulses tx_err immediately; no retry logic exists.

Test Plan:
- Send 0xF4, device model clocks at 10 kHz and acks. Required:
  - ps2_clk_oe held low exactly INHIBIT_CYCLES cycles.
  - Bits sampled on device rising edges: 0, 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - tx_done pulses once; tx_busy falls in the same cycle.
- Send 0xED, then 0xFF. Required: parity bits 1 and 1, both frames acked, two tx_done pulses.
- Device never clocks after the start bit. Required: tx_err pulse after TIMEOUT_CYCLES; both oe=0; tx_done stays 0.
- Device clocks 11 edges but leaves data high on the ack. Required: tx_err pulse.
  - With PS2_HOST_TX_RETRY_EN defined: a second inhibit phase with an identical frame; an ack on the retry gives tx_done only.
- Pulse tx_start again during SHIFT with tx_data=0x00. Required: ignored; the frame in progress is unchanged.
- Drive rst low during SHIFT with ps2_data_oe=1. Required: both oe go to 0 asynchronously; no pulse; tx_busy=0. A new tx_start after reset completes normally.
